// File: rtl/cache_arbiter_if.sv
// Line-port bundle between the icache, the dcache, the arbiter and physical memory.
// The arbiter takes the slave view; the cache/memory side takes the master view.
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] i_pmem_address;
    logic              i_pmem_read;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic [ADDR_W-1:0] d_pmem_address;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_pmem_address, i_pmem_read,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output mem_address, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_pmem_address, i_pmem_read,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_address, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the icache and dcache: one transaction
// at a time, registered memory request, combinational response routing, one-cycle release.
module cache_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int FIXED_PRI = 0
) (
    input logic            clk,
    input logic            rst,
    cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RELEASE} state_t;
    typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_t;

    state_t            r_state;
    src_t              r_last_served;
    logic [ADDR_W-1:0] r_mem_address;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [LINE_W-1:0] r_mem_wdata;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;

    assign w_i_req = bus.i_pmem_read;
    assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

    // On a tie the dcache wins when priority is fixed, otherwise whoever was not served last.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_i_req && w_d_req) begin
            if ((FIXED_PRI != 0) || (r_last_served == SRC_I)) begin
                w_grant_d = 1'b1;
            end else begin
                w_grant_i = 1'b1;
            end
        end else if (w_d_req) begin
            w_grant_d = 1'b1;
        end else if (w_i_req) begin
            w_grant_i = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_served <= SRC_I;
            r_mem_address <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        // A simultaneous read+write from the dcache is a writeback.
                        r_mem_address <= bus.d_pmem_address;
                        r_mem_write   <= bus.d_pmem_write;
                        r_mem_read    <= ~bus.d_pmem_write;
                        r_mem_wdata   <= bus.d_pmem_wdata;
                        r_state       <= D_BUSY;
                    end else if (w_grant_i) begin
                        r_mem_address <= bus.i_pmem_address;
                        r_mem_write   <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_state       <= I_BUSY;
                    end
                end
                I_BUSY: begin
                    if (bus.mem_resp) begin
                        r_last_served <= SRC_I;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_state       <= RELEASE;
                    end
                end
                D_BUSY: begin
                    if (bus.mem_resp) begin
                        r_last_served <= SRC_D;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_address  = r_mem_address;
    assign bus.mem_read     = r_mem_read;
    assign bus.mem_write    = r_mem_write;
    assign bus.mem_wdata    = r_mem_wdata;

    // Read data is shared; the per-cache resp is the only qualifier.
    assign bus.i_pmem_rdata = bus.mem_rdata;
    assign bus.d_pmem_rdata = bus.mem_rdata;
    assign bus.i_pmem_resp  = (r_state == I_BUSY) & bus.mem_resp;
    assign bus.d_pmem_resp  = (r_state == D_BUSY) & bus.mem_resp;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized cache/memory traffic
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] c_ia, c_da;
    logic          c_ir, c_dr, c_dw, c_mresp, sel;
    logic [LW-1:0] c_dwd, c_mrd;
    int checks = 0;
    int failures = 0;

    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) b0 ();
    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) b1 ();

    assign b0.i_pmem_address = c_ia;  assign b1.i_pmem_address = c_ia;
    assign b0.i_pmem_read    = c_ir;  assign b1.i_pmem_read    = c_ir;
    assign b0.d_pmem_address = c_da;  assign b1.d_pmem_address = c_da;
    assign b0.d_pmem_read    = c_dr;  assign b1.d_pmem_read    = c_dr;
    assign b0.d_pmem_write   = c_dw;  assign b1.d_pmem_write   = c_dw;
    assign b0.d_pmem_wdata   = c_dwd; assign b1.d_pmem_wdata   = c_dwd;
    assign b0.mem_rdata      = c_mrd; assign b1.mem_rdata      = c_mrd;
    assign b0.mem_resp       = c_mresp & ~sel;
    assign b1.mem_resp       = c_mresp & sel;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRI(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRI(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    logic          obs_mread, obs_mwrite, obs_iresp, obs_dresp;
    logic [AW-1:0] obs_maddr;
    logic [LW-1:0] obs_mwdata, obs_irdata, obs_drdata;
    assign obs_mread  = sel ? b1.mem_read     : b0.mem_read;
    assign obs_mwrite = sel ? b1.mem_write    : b0.mem_write;
    assign obs_maddr  = sel ? b1.mem_address  : b0.mem_address;
    assign obs_mwdata = sel ? b1.mem_wdata    : b0.mem_wdata;
    assign obs_iresp  = sel ? b1.i_pmem_resp  : b0.i_pmem_resp;
    assign obs_dresp  = sel ? b1.d_pmem_resp  : b0.d_pmem_resp;
    assign obs_irdata = sel ? b1.i_pmem_rdata : b0.i_pmem_rdata;
    assign obs_drdata = sel ? b1.d_pmem_rdata : b0.d_pmem_rdata;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_ia = '0; c_da = '0; c_ir = 1'b0; c_dr = 1'b0; c_dw = 1'b0;
        c_dwd = '0; c_mrd = '0; c_mresp = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            c_mresp = (k == 3 || k == 7);
            c_mrd = {8{$urandom()}};
            @(negedge clk);
            if (k == 0) begin
                checks++; if (obs_maddr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", obs_maddr); end
                checks++; if (obs_mwdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", obs_mwdata); end
            end
            checks++; if (obs_mread !== 1'b0) begin failures++; $display("FAIL reset_mread k=%0d got=%b exp=0", k, obs_mread); end
            checks++; if (obs_mwrite !== 1'b0) begin failures++; $display("FAIL reset_mwrite k=%0d got=%b exp=0", k, obs_mwrite); end
            checks++; if (obs_iresp !== 1'b0) begin failures++; $display("FAIL reset_iresp k=%0d got=%b exp=0", k, obs_iresp); end
            checks++; if (obs_dresp !== 1'b0) begin failures++; $display("FAIL reset_dresp k=%0d got=%b exp=0", k, obs_dresp); end
            nxt();
        end
        c_mresp = 1'b0;
    endtask

    task automatic test_single_iread();
        logic [LW-1:0] a5;
        a5 = {32{8'hA5}};
        sel = 1'b0;
        do_reset();
        c_ia = 32'h0000_1000;
        c_ir = 1'b1;
        @(negedge clk);
        checks++; if (obs_mread !== 1'b0) begin failures++; $display("FAIL iread_early got=%b exp=0", obs_mread); end
        nxt();
        for (int k = 1; k <= 5; k++) begin
            c_mresp = (k == 5);
            c_mrd = (k == 5) ? a5 : '0;
            @(negedge clk);
            checks++; if (obs_mread !== 1'b1) begin failures++; $display("FAIL iread_mread k=%0d got=%b exp=1", k, obs_mread); end
            checks++; if (obs_maddr !== 32'h0000_1000) begin failures++; $display("FAIL iread_addr k=%0d got=%h exp=00001000", k, obs_maddr); end
            checks++; if (obs_iresp !== (k == 5)) begin failures++; $display("FAIL iread_iresp k=%0d got=%b exp=%b", k, obs_iresp, (k == 5)); end
            checks++; if (obs_dresp !== 1'b0) begin failures++; $display("FAIL iread_dresp k=%0d got=%b exp=0", k, obs_dresp); end
            if (k == 5) begin
                checks++; if (obs_irdata !== a5) begin failures++; $display("FAIL iread_rdata got=%h exp=%h", obs_irdata, a5); end
            end
            nxt();
        end
        c_ir = 1'b0;
        c_mresp = 1'b0;
        @(negedge clk);
        checks++; if (obs_mread !== 1'b0) begin failures++; $display("FAIL iread_release got=%b exp=0", obs_mread); end
        nxt();
    endtask

    task automatic test_conflict();
        logic [LW-1:0] wd;
        wd = {8{$urandom()}};
        sel = 1'b0;
        do_reset();
        c_ia = 32'h100; c_ir = 1'b1;
        c_da = 32'h200; c_dw = 1'b1; c_dwd = wd;
        nxt();
        @(negedge clk);
        checks++; if (obs_mwrite !== 1'b1 || obs_mread !== 1'b0) begin failures++; $display("FAIL conflict_first_op got=r%b w%b exp=r0 w1", obs_mread, obs_mwrite); end
        checks++; if (obs_maddr !== 32'h200) begin failures++; $display("FAIL conflict_first_addr got=%h exp=200", obs_maddr); end
        checks++; if (obs_mwdata !== wd) begin failures++; $display("FAIL conflict_wdata got=%h exp=%h", obs_mwdata, wd); end
        nxt();
        c_mresp = 1'b1;
        @(negedge clk);
        checks++; if (obs_dresp !== 1'b1 || obs_iresp !== 1'b0) begin failures++; $display("FAIL conflict_dresp got=d%b i%b exp=d1 i0", obs_dresp, obs_iresp); end
        nxt();
        c_mresp = 1'b0; c_dw = 1'b0;
        @(negedge clk);
        checks++; if (obs_mread !== 1'b0 || obs_mwrite !== 1'b0) begin failures++; $display("FAIL conflict_release got=r%b w%b exp=r0 w0", obs_mread, obs_mwrite); end
        nxt();
        @(negedge clk);
        checks++; if (obs_mread !== 1'b0) begin failures++; $display("FAIL conflict_idle got=%b exp=0", obs_mread); end
        nxt();
        @(negedge clk);
        checks++; if (obs_mread !== 1'b1 || obs_mwrite !== 1'b0) begin failures++; $display("FAIL conflict_second_op got=r%b w%b exp=r1 w0", obs_mread, obs_mwrite); end
        checks++; if (obs_maddr !== 32'h100) begin failures++; $display("FAIL conflict_second_addr got=%h exp=100", obs_maddr); end
        nxt();
        c_mresp = 1'b1;
        @(negedge clk);
        checks++; if (obs_iresp !== 1'b1 || obs_dresp !== 1'b0) begin failures++; $display("FAIL conflict_iresp got=i%b d%b exp=i1 d0", obs_iresp, obs_dresp); end
        nxt();
        c_mresp = 1'b0; c_ir = 1'b0;
        nxt();
    endtask

    // Both caches hold their requests; winners follow the priority rule from reset.
    task automatic test_grant_order(input logic s);
        logic last_d, exp_d, got;
        logic [LW-1:0] wd;
        sel = s;
        do_reset();
        wd = {8{$urandom()}};
        c_ia = 32'h100; c_ir = 1'b1;
        c_da = 32'h200; c_dw = 1'b1; c_dwd = wd;
        last_d = 1'b0;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                @(negedge clk);
                if (obs_mread || obs_mwrite) got = 1'b1;
                else nxt();
            end
            checks++;
            if (!got) begin
                failures++; $display("FAIL order_timeout pri=%0d t=%0d got=none exp=grant", s, t);
            end else begin
                exp_d = s || !last_d;
                last_d = exp_d;
                if (obs_mwrite !== exp_d) begin failures++; $display("FAIL order_owner pri=%0d t=%0d got=%s exp=%s", s, t, obs_mwrite ? "D" : "I", exp_d ? "D" : "I"); end
                checks++;
                if (obs_maddr !== (exp_d ? 32'h200 : 32'h100)) begin failures++; $display("FAIL order_addr pri=%0d t=%0d got=%h", s, t, obs_maddr); end
                nxt();
                c_mresp = 1'b1;
                c_mrd = {8{$urandom()}};
                @(negedge clk);
                checks++;
                if (obs_dresp !== exp_d || obs_iresp !== !exp_d) begin failures++; $display("FAIL order_resp pri=%0d t=%0d got=d%b i%b exp=d%b", s, t, obs_dresp, obs_iresp, exp_d); end
                nxt();
                c_mresp = 1'b0;
            end
        end
        idle_inputs();
        nxt();
        nxt();
    endtask

    task automatic test_addr_hold();
        sel = 1'b0;
        do_reset();
        c_da = 32'h200; c_dr = 1'b1;
        nxt();
        c_da = 32'h300;
        for (int k = 0; k < 4; k++) begin
            c_mresp = (k == 3);
            @(negedge clk);
            checks++; if (obs_maddr !== 32'h200) begin failures++; $display("FAIL hold_addr k=%0d got=%h exp=200", k, obs_maddr); end
            checks++; if (obs_mread !== 1'b1) begin failures++; $display("FAIL hold_mread k=%0d got=%b exp=1", k, obs_mread); end
            checks++; if (obs_dresp !== (k == 3)) begin failures++; $display("FAIL hold_dresp k=%0d got=%b exp=%b", k, obs_dresp, (k == 3)); end
            nxt();
        end
        idle_inputs();
        nxt();
    endtask

    task automatic test_reset_in_busy();
        sel = 1'b0;
        do_reset();
        c_ia = 32'h40; c_ir = 1'b1;
        nxt();
        @(negedge clk);
        checks++; if (obs_mread !== 1'b1) begin failures++; $display("FAIL rbusy_pre got=%b exp=1", obs_mread); end
        nxt();
        rst = 1'b1; c_ir = 1'b0;
        nxt();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (obs_mread !== 1'b0) begin failures++; $display("FAIL rbusy_mread got=%b exp=0", obs_mread); end
        checks++; if (obs_maddr !== '0) begin failures++; $display("FAIL rbusy_addr got=%h exp=0", obs_maddr); end
        nxt();
        c_mresp = 1'b1; c_mrd = {8{$urandom()}};
        @(negedge clk);
        checks++; if (obs_iresp !== 1'b0 || obs_dresp !== 1'b0) begin failures++; $display("FAIL rbusy_resp got=i%b d%b exp=i0 d0", obs_iresp, obs_dresp); end
        nxt();
        c_mresp = 1'b0;
        @(negedge clk);
        checks++; if (obs_mread !== 1'b0 || obs_mwrite !== 1'b0) begin failures++; $display("FAIL rbusy_after got=r%b w%b exp=r0 w0", obs_mread, obs_mwrite); end
        nxt();
    endtask

    // Randomized caches that hold requests until served, and a memory with random latency.
    task automatic test_random(input logic s, input int ntx);
        logic i_pend, d_pend, d_rd, d_wr, prev_pi, prev_pd, resp_prev, owner_d, last_d;
        logic exp_r, exp_w, exp_ir, exp_dr;
        logic [AW-1:0] i_addr, d_addr;
        logic [LW-1:0] d_data;
        int i_gap, d_gap, ph, ph_prev, lat, done, cyc;
        i_pend = 0; d_pend = 0; d_rd = 0; d_wr = 0; prev_pi = 0; prev_pd = 0;
        resp_prev = 0; owner_d = 0; last_d = 0; i_addr = '0; d_addr = '0; d_data = '0;
        i_gap = 0; d_gap = 0; ph = 0; ph_prev = 0; lat = 0; done = 0; cyc = 0;
        sel = s;
        do_reset();
        while (done < ntx && cyc < 4000) begin
            cyc++;
            if (resp_prev) begin
                if (owner_d) begin d_pend = 1'b0; d_gap = $urandom_range(0, 2); end
                else begin i_pend = 1'b0; i_gap = $urandom_range(0, 2); end
                last_d = owner_d;
                done++;
            end
            // phase: 0 idle, 1 transaction in flight, 2 release cycle
            if (ph_prev == 1) ph = resp_prev ? 2 : 1;
            else if (ph_prev == 0 && (prev_pi || prev_pd)) begin
                ph = 1;
                owner_d = prev_pd && (!prev_pi || s || !last_d);
                lat = $urandom_range(0, 4);
            end else ph = 0;
            if (!i_pend) begin
                if (i_gap > 0) i_gap--;
                else if ($urandom_range(0, 1) == 1) begin i_pend = 1'b1; i_addr = $urandom(); end
            end
            if (!d_pend) begin
                if (d_gap > 0) d_gap--;
                else if ($urandom_range(0, 1) == 1) begin
                    d_pend = 1'b1; d_addr = $urandom(); d_data = {8{$urandom()}};
                    case ($urandom_range(0, 2))
                        0:       begin d_rd = 1'b1; d_wr = 1'b0; end
                        1:       begin d_rd = 1'b0; d_wr = 1'b1; end
                        default: begin d_rd = 1'b1; d_wr = 1'b1; end
                    endcase
                end
            end
            c_ir = i_pend;
            c_ia = i_pend ? i_addr : AW'($urandom());
            c_dr = d_pend & d_rd;
            c_dw = d_pend & d_wr;
            c_da = d_pend ? d_addr : AW'($urandom());
            c_dwd = d_pend ? d_data : {8{$urandom()}};
            c_mresp = (ph == 1 && lat == 0);
            c_mrd = {8{$urandom()}};
            if (ph == 1 && lat > 0) lat--;
            @(negedge clk);
            exp_w = (ph == 1) && owner_d && d_wr;
            exp_r = (ph == 1) && !(owner_d && d_wr);
            exp_ir = c_mresp && !owner_d;
            exp_dr = c_mresp && owner_d;
            checks++; if (obs_mread !== exp_r) begin failures++; $display("FAIL rnd_mread pri=%0d cyc=%0d got=%b exp=%b", s, cyc, obs_mread, exp_r); end
            checks++; if (obs_mwrite !== exp_w) begin failures++; $display("FAIL rnd_mwrite pri=%0d cyc=%0d got=%b exp=%b", s, cyc, obs_mwrite, exp_w); end
            checks++; if (obs_iresp !== exp_ir) begin failures++; $display("FAIL rnd_iresp pri=%0d cyc=%0d got=%b exp=%b", s, cyc, obs_iresp, exp_ir); end
            checks++; if (obs_dresp !== exp_dr) begin failures++; $display("FAIL rnd_dresp pri=%0d cyc=%0d got=%b exp=%b", s, cyc, obs_dresp, exp_dr); end
            checks++; if (obs_irdata !== c_mrd || obs_drdata !== c_mrd) begin failures++; $display("FAIL rnd_rdata pri=%0d cyc=%0d got=%h exp=%h", s, cyc, obs_irdata, c_mrd); end
            if (ph == 1) begin
                checks++;
                if (obs_maddr !== (owner_d ? d_addr : i_addr)) begin failures++; $display("FAIL rnd_addr pri=%0d cyc=%0d got=%h exp=%h", s, cyc, obs_maddr, owner_d ? d_addr : i_addr); end
            end
            if (exp_w) begin
                checks++; if (obs_mwdata !== d_data) begin failures++; $display("FAIL rnd_wdata pri=%0d cyc=%0d got=%h exp=%h", s, cyc, obs_mwdata, d_data); end
            end
            prev_pi = i_pend;
            prev_pd = d_pend;
            ph_prev = ph;
            resp_prev = c_mresp;
            nxt();
        end
        checks++;
        if (done < ntx) begin failures++; $display("FAIL rnd_timeout pri=%0d got=%0d exp=%0d", s, done, ntx); end
        idle_inputs();
        nxt();
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        idle_inputs();
        test_reset();
        test_single_iread();
        test_conflict();
        test_grant_order(1'b0);
        test_grant_order(1'b1);
        test_addr_hold();
        test_reset_in_busy();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
